// File: rtl/cnn_pkg.sv
// Shared sizing defaults and window-index helper for the CNN datapath.
package cnn_pkg;

    localparam int unsigned CNN_BITWIDTH     = 8;
    localparam int unsigned CNN_DATACHANNEL  = 3;
    localparam int unsigned CNN_FILTERHEIGHT = 5;
    localparam int unsigned CNN_FILTERWIDTH  = 5;
    localparam int unsigned CNN_DATAWIDTH    = 28;
    localparam int unsigned CNN_DATAHEIGHT   = 28;

    localparam int unsigned PIXEL_BITS  = CNN_BITWIDTH * CNN_DATACHANNEL;
    localparam int unsigned WINDOW_BITS = PIXEL_BITS * CNN_FILTERHEIGHT * CNN_FILTERWIDTH;
    localparam int unsigned COL_W       = $clog2(CNN_DATAWIDTH);
    localparam int unsigned ROW_W       = $clog2(CNN_DATAHEIGHT);

    // Flattened element index of (row r, column c, channel ch) in a window;
    // element i pairs with weight element i at the kernel.
    function automatic int unsigned win_idx(
        input int unsigned r,
        input int unsigned c,
        input int unsigned ch,
        input int unsigned fw,
        input int unsigned dc
    );
        return (r * fw + c) * dc + ch;
    endfunction

endpackage

// File: rtl/conv_window_buffer_line.sv
// One image line of pixel delay: dout is the pixel written DEPTH accepted pixels ago.
module line_buffer_row
    import cnn_pkg::*;
#(
    parameter int unsigned DEPTH = 28,
    parameter int unsigned WIDTH = 24
) (
    input  logic             clk,
    input  logic             we,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    // Shift the delay line by one position on each accepted pixel.
    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[0] = din;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                mem_d[i] = mem_q[i-1];
            end
        end
    end

    // Storage needs no reset: stale lines never reach a valid window.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign dout = mem_q[DEPTH-1];

endmodule

// File: rtl/conv_window_buffer.sv
// Sliding-window generator: raster pixel stream in, registered flattened
// FILTERHEIGHT x FILTERWIDTH x DATACHANNEL window out, stride 1, no padding.
module conv_window_buffer
    import cnn_pkg::*;
#(
    parameter int unsigned BITWIDTH     = 8,
    parameter int unsigned DATACHANNEL  = 3,
    parameter int unsigned FILTERHEIGHT = 5,
    parameter int unsigned FILTERWIDTH  = 5,
    parameter int unsigned DATAWIDTH    = 28,
    parameter int unsigned DATAHEIGHT   = 28
) (
    input  logic                                                  clk,
    input  logic                                                  rst,
    input  logic                                                  in_valid,
    input  logic [BITWIDTH*DATACHANNEL-1:0]                       in_data,
    output logic                                                  out_valid,
    output logic [BITWIDTH*DATACHANNEL*FILTERHEIGHT*FILTERWIDTH-1:0] out_window,
    output logic                                                  out_last
);

    localparam int unsigned PIX_W = BITWIDTH * DATACHANNEL;
    localparam int unsigned WIN_W = PIX_W * FILTERHEIGHT * FILTERWIDTH;
    localparam int unsigned CW    = (DATAWIDTH  > 1) ? $clog2(DATAWIDTH)  : 1;
    localparam int unsigned RW    = (DATAHEIGHT > 1) ? $clog2(DATAHEIGHT) : 1;

    localparam logic [CW-1:0] COL_LAST  = CW'(DATAWIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(DATAHEIGHT - 1);
    localparam logic [CW-1:0] COL_FIRST = CW'(FILTERWIDTH - 1);
    localparam logic [RW-1:0] ROW_FIRST = RW'(FILTERHEIGHT - 1);

    logic [CW-1:0]    col_q, col_d;
    logic [RW-1:0]    row_q, row_d;
    logic [PIX_W-1:0] lb_out [FILTERHEIGHT-1];
    logic [PIX_W-1:0] slice  [FILTERHEIGHT];
    logic [PIX_W-1:0] win_q  [FILTERHEIGHT][FILTERWIDTH];
    logic [PIX_W-1:0] win_d  [FILTERHEIGHT][FILTERWIDTH];
    logic             fire;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic [WIN_W-1:0] out_window_q, out_window_d;

    // Chained line delays: lb_out[k] is the pixel k+1 rows above the incoming one.
    for (genvar k = 0; k < FILTERHEIGHT - 1; k++) begin : g_lb
        logic [PIX_W-1:0] lb_in;
        if (k == 0) begin : g_head
            assign lb_in = in_data;
        end else begin : g_tail
            assign lb_in = lb_out[k-1];
        end
        line_buffer_row #(
            .DEPTH (DATAWIDTH),
            .WIDTH (PIX_W)
        ) u_row (
            .clk  (clk),
            .we   (in_valid),
            .din  (lb_in),
            .dout (lb_out[k])
        );
    end

    // Column slice at the current column, oldest row at index 0.
    always_comb begin
        for (int unsigned r = 0; r < FILTERHEIGHT - 1; r++) begin
            slice[r] = lb_out[FILTERHEIGHT-2-r];
        end
        slice[FILTERHEIGHT-1] = in_data;
    end

    // Raster position counters, advanced only by accepted pixels.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (in_valid) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // Window shifts left one column; the new slice enters on the right.
    always_comb begin
        win_d = win_q;
        if (in_valid) begin
            for (int unsigned r = 0; r < FILTERHEIGHT; r++) begin
                for (int unsigned c = 0; c + 1 < FILTERWIDTH; c++) begin
                    win_d[r][c] = win_q[r][c+1];
                end
                win_d[r][FILTERWIDTH-1] = slice[r];
            end
        end
    end

    // Valid decision on the position of the pixel being accepted; window packed on fire.
    always_comb begin
        fire         = in_valid && (row_q >= ROW_FIRST) && (col_q >= COL_FIRST);
        out_valid_d  = fire;
        out_last_d   = fire && (row_q == ROW_LAST) && (col_q == COL_LAST);
        out_window_d = out_window_q;
        if (fire) begin
            for (int unsigned r = 0; r < FILTERHEIGHT; r++) begin
                for (int unsigned c = 0; c < FILTERWIDTH; c++) begin
                    out_window_d[win_idx(r, c, 0, FILTERWIDTH, DATACHANNEL)*BITWIDTH +: PIX_W] = win_d[r][c];
                end
            end
        end
    end

    // Counters and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q        <= '0;
            row_q        <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_window_q <= '0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            out_window_q <= out_window_d;
        end
    end

    // Window contents need no reset.
    always_ff @(posedge clk) begin
        win_q <= win_d;
    end

    assign out_valid  = out_valid_q;
    assign out_last   = out_last_q;
    assign out_window = out_window_q;

endmodule

// File: tb/tb_conv_window_buffer.sv
// Scoreboard bench for conv_window_buffer using a frame-image reference model.
module tb_conv_window_buffer;
    import cnn_pkg::*;

    localparam int unsigned BW = 8;
    localparam int unsigned DC = 3;
    localparam int unsigned FH = 3;
    localparam int unsigned FW = 3;
    localparam int unsigned DW = 8;
    localparam int unsigned DH = 6;
    localparam int unsigned PIX_W = BW * DC;
    localparam int unsigned WIN_W = PIX_W * FH * FW;
    localparam int unsigned NWIN  = (DH - FH + 1) * (DW - FW + 1);

    typedef struct packed {
        logic             last;
        logic [WIN_W-1:0] win;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic [PIX_W-1:0] in_data = '0;
    logic             out_valid;
    logic             out_last;
    logic [WIN_W-1:0] out_window;

    always #5 clk = ~clk;

    conv_window_buffer #(
        .BITWIDTH     (BW),
        .DATACHANNEL  (DC),
        .FILTERHEIGHT (FH),
        .FILTERWIDTH  (FW),
        .DATAWIDTH    (DW),
        .DATAHEIGHT   (DH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_window (out_window),
        .out_last   (out_last)
    );

    int               checks = 0;
    int               failures = 0;
    exp_t             exp_q[$];
    logic [WIN_W-1:0] got_q[$];
    logic             got_last_q[$];
    logic [PIX_W-1:0] img [DH][DW];
    int unsigned      mrow = 0;
    int unsigned      mcol = 0;
    logic             acc_prev = 1'b0;
    logic [WIN_W-1:0] hold_ref = '0;

    int unsigned offs0 [9] = '{0, 1, 2, 8, 9, 10, 16, 17, 18};
    int unsigned offsL [9] = '{29, 30, 31, 37, 38, 39, 45, 46, 47};

    task automatic chk(input string name, input logic [WIN_W-1:0] got, input logic [WIN_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    function automatic logic [BW-1:0] elem(input logic [WIN_W-1:0] w, input int unsigned r,
                                           input int unsigned c, input int unsigned ch);
        return w[win_idx(r, c, ch, FW, DC)*BW +: BW];
    endfunction

    function automatic logic [PIX_W-1:0] pat(input int unsigned base, input int unsigned row,
                                             input int unsigned col);
        logic [PIX_W-1:0] p;
        for (int unsigned ch = 0; ch < DC; ch++) p[ch*BW +: BW] = 8'(ch*64 + base + row*8 + col);
        return p;
    endfunction

    // Reference: remember the frame as an image; a window is the FHxFW block ending here.
    task automatic model_accept(input logic [PIX_W-1:0] p);
        exp_t e;
        img[mrow][mcol] = p;
        if (mrow >= FH - 1 && mcol >= FW - 1) begin
            e.win  = '0;
            e.last = (mrow == DH - 1) && (mcol == DW - 1);
            for (int unsigned r = 0; r < FH; r++)
                for (int unsigned c = 0; c < FW; c++)
                    e.win[(r*FW + c)*PIX_W +: PIX_W] = img[mrow-FH+1+r][mcol-FW+1+c];
            exp_q.push_back(e);
        end
        mcol++;
        if (mcol == DW) begin
            mcol = 0;
            mrow++;
            if (mrow == DH) mrow = 0;
        end
    endtask

    task automatic drive(input logic v, input logic [PIX_W-1:0] p);
        in_valid = v;
        in_data  = p;
        if (v) model_accept(p);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) drive(1'b0, PIX_W'($urandom));
    endtask

    // gap_mode: 0 none, 1 alternate 1/0, 2 random idles; rnd selects random pixel values.
    task automatic send_frame(input int unsigned base, input int unsigned gap_mode, input bit rnd);
        for (int unsigned r = 0; r < DH; r++) begin
            for (int unsigned c = 0; c < DW; c++) begin
                if (gap_mode == 2) while ($urandom_range(0, 2) == 0) idle(1);
                drive(1'b1, rnd ? PIX_W'($urandom) : pat(base, r, c));
                if (gap_mode == 1) idle(1);
            end
        end
    endtask

    task automatic do_reset();
        idle(2);
        chk("pending_before_reset", WIN_W'(exp_q.size()), '0);
        exp_q.delete();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst  = 1'b0;
        mrow = 0;
        mcol = 0;
        chk("reset_out_valid", WIN_W'(out_valid), '0);
        chk("reset_out_last", WIN_W'(out_last), '0);
        chk("reset_out_window", out_window, '0);
    endtask

    task automatic check_ch0(input string name, input logic [WIN_W-1:0] w, input int unsigned base,
                             input bit last_win);
        for (int unsigned k = 0; k < 9; k++)
            chk(name, WIN_W'(elem(w, k / 3, k % 3, 0)),
                WIN_W'(8'(base + (last_win ? offsL[k] : offs0[k]))));
    endtask

    task automatic check_frame(input string name, input int unsigned base, input int unsigned nframes);
        int unsigned nl;
        idle(3);
        chk({name, "_count"}, WIN_W'(got_q.size()), WIN_W'(NWIN * nframes));
        if (got_q.size() == NWIN * nframes) begin
            check_ch0({name, "_first"}, got_q[(nframes-1)*NWIN], base, 1'b0);
            check_ch0({name, "_lastwin"}, got_q[nframes*NWIN-1], base, 1'b1);
            nl = 0;
            foreach (got_last_q[i]) if (got_last_q[i]) nl++;
            chk({name, "_last_count"}, WIN_W'(nl), WIN_W'(nframes));
            chk({name, "_last_pos"}, WIN_W'(got_last_q[nframes*NWIN-1]), WIN_W'(1));
        end
        got_q.delete();
        got_last_q.delete();
    endtask

    always @(posedge clk) acc_prev <= in_valid && !rst;

    // Monitor: pops the scoreboard whenever the DUT presents a window.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            hold_ref = '0;
        end else if (out_valid) begin
            chk("valid_after_accept", WIN_W'(acc_prev), WIN_W'(1));
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_window: got %h required no output", out_window);
            end else begin
                e = exp_q.pop_front();
                chk("window", out_window, e.win);
                chk("out_last", WIN_W'(out_last), WIN_W'(e.last));
            end
            got_q.push_back(out_window);
            got_last_q.push_back(out_last);
            hold_ref = out_window;
        end else begin
            chk("idle_out_last", WIN_W'(out_last), '0);
            chk("idle_window_hold", out_window, hold_ref);
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_out_valid", WIN_W'(out_valid), '0);
        chk("reset_out_last", WIN_W'(out_last), '0);
        chk("reset_out_window", out_window, '0);

        // Continuous frame with structured pixels, plus multi-channel element.
        send_frame(0, 0, 1'b0);
        if (got_q.size() > 0) chk("multichannel_i14", WIN_W'(elem(got_q[0], 1, 1, 2)), WIN_W'(137));
        check_frame("basic", 0, 1);

        // Same frame with alternating idle cycles.
        send_frame(0, 1, 1'b0);
        check_frame("gaps", 0, 1);

        // Back-to-back frames.
        send_frame(0, 0, 1'b0);
        send_frame(100, 0, 1'b0);
        check_frame("b2b", 100, 2);

        // Mid-frame reset after 13 pixels.
        for (int unsigned k = 0; k < 13; k++) drive(1'b1, pat(50, k / DW, k % DW));
        do_reset();
        got_q.delete();
        got_last_q.delete();
        send_frame(0, 0, 1'b0);
        check_frame("post_reset", 0, 1);

        // Random pixels with random gaps, and a random mid-frame reset.
        for (int f = 0; f < 3; f++) send_frame(0, 2, 1'b1);
        for (int unsigned k = 0; k < $urandom_range(1, DW*DH - 1); k++) drive(1'b1, PIX_W'($urandom));
        do_reset();
        for (int f = 0; f < 2; f++) send_frame(0, 2, 1'b1);
        idle(3);
        chk("scoreboard_empty", WIN_W'(exp_q.size()), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
